scan_config_loader: RTL

Drives the configuration scan chain of the runtime-enforcement core from a byte stream: one `start` clears the chain, shifts in a `CHAIN_LEN`-bit image, then optionally recirculates the chain once to check integrity. It sits between the host/boot interface and the core's `scan_in`/`scan_en`/`scan_reset`/`scan_out` pins. It is the transmitting end of the scan interface whose receiver is the config module. The chain contents are preserved by the verify pass.

---
 rtl/scan_config_loader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/scan_config_loader.sv
// Byte-stream driver for the configuration scan chain: clears the chain, shifts in
// a CHAIN_LEN-bit image LSB-first, and optionally recirculates it once to check integrity.
module scan_config_loader #(
    parameter int CHAIN_LEN = 1144,
    parameter int CNT_BITS  = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       verify,
    input  logic       abort,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       scan_in,
    output logic       scan_en,
    output logic       scan_reset,
    input  logic       scan_out,
    output logic       busy,
    output logic       done,
    output logic       verify_ok,
    output logic [7:0] crc_out
);

    localparam logic [CNT_BITS-1:0] NUM_BYTES = CNT_BITS'(CHAIN_LEN / 8);
    localparam logic [CNT_BITS-1:0] LAST_VCYC = CNT_BITS'(CHAIN_LEN - 1);
    localparam logic [CNT_BITS-1:0] CNT_ZERO  = {CNT_BITS{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // One bit of CRC-8, polynomial 0x07, MSB-first feedback.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        crc8_step = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    state_t              state_r, state_s;
    logic [7:0]          sh_r, sh_s;
    logic [3:0]          bits_left_r, bits_left_s;
    logic [CNT_BITS-1:0] bytes_rem_r, bytes_rem_s;
    logic [CNT_BITS-1:0] vcnt_r, vcnt_s;
    logic [7:0]          crc_r, crc_s;
    logic [7:0]          crc2_r, crc2_s;
    logic                verify_mode_r, verify_mode_s;
    logic                verify_ok_r, verify_ok_s;
    logic [7:0]          crc_out_r, crc_out_s;
    logic                byte_ready_r, byte_ready_s;
    logic                scan_in_r, scan_in_s;
    logic                scan_en_r, scan_en_s;
    logic                scan_reset_r, scan_reset_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                accept_s;

    assign accept_s = byte_valid & byte_ready_r;

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_s       = state_r;
        sh_s          = sh_r;
        bits_left_s   = bits_left_r;
        bytes_rem_s   = bytes_rem_r;
        vcnt_s        = vcnt_r;
        crc_s         = crc_r;
        crc2_s        = crc2_r;
        verify_mode_s = verify_mode_r;
        verify_ok_s   = verify_ok_r;
        crc_out_s     = crc_out_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s       = ST_CLEAR;
                    verify_mode_s = verify;
                    verify_ok_s   = 1'b0;
                    crc_out_s     = 8'h00;
                    bytes_rem_s   = NUM_BYTES;
                    bits_left_s   = 4'd0;
                    vcnt_s        = CNT_ZERO;
                    crc_s         = 8'h00;
                    crc2_s        = 8'h00;
                    sh_s          = 8'h00;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_s = ST_LOAD;
            end
            ST_LOAD: begin
                // The registered scan_en is exactly what the chain saw this cycle.
                if (scan_en_r) begin
                    sh_s        = {1'b0, sh_r[7:1]};
                    bits_left_s = bits_left_r - 4'd1;
                    crc_s       = crc8_step(crc_r, sh_r[0]);
                end else begin
                    sh_s        = sh_r;
                end
                if (accept_s) begin
                    sh_s        = byte_in;
                    bits_left_s = 4'd8;
                    bytes_rem_s = bytes_rem_r - {{(CNT_BITS-1){1'b0}}, 1'b1};
                end else begin
                    bytes_rem_s = bytes_rem_r;
                end
                if ((bytes_rem_s == CNT_ZERO) && (bits_left_s == 4'd0)) begin
                    state_s = verify_mode_r ? ST_VERIFY : ST_DONE;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_VERIFY: begin
                crc2_s = crc8_step(crc2_r, scan_out);
                if (vcnt_r == LAST_VCYC) begin
                    verify_ok_s = (crc2_s == crc_r);
                    state_s     = ST_DONE;
                end else begin
                    vcnt_s = vcnt_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                crc_out_s = crc_r;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Abort wins over everything and leaves the previous results untouched.
        if (abort) begin
            state_s     = ST_IDLE;
            verify_ok_s = verify_ok_r;
            crc_out_s   = crc_out_r;
        end else begin
            state_s = state_s;
        end

        scan_en_s    = ((state_s == ST_LOAD) && (bits_left_s != 4'd0)) || (state_s == ST_VERIFY);
        scan_in_s    = (state_s == ST_LOAD) ? sh_s[0] : 1'b0;
        byte_ready_s = (state_s == ST_LOAD) && (bits_left_s <= 4'd1) && (bytes_rem_s != CNT_ZERO);
        scan_reset_s = (state_s == ST_CLEAR);
        busy_s       = (state_s != ST_IDLE);
        done_s       = (state_s == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            sh_r          <= 8'h00;
            bits_left_r   <= 4'd0;
            bytes_rem_r   <= CNT_ZERO;
            vcnt_r        <= CNT_ZERO;
            crc_r         <= 8'h00;
            crc2_r        <= 8'h00;
            verify_mode_r <= 1'b0;
            verify_ok_r   <= 1'b0;
            crc_out_r     <= 8'h00;
            byte_ready_r  <= 1'b0;
            scan_in_r     <= 1'b0;
            scan_en_r     <= 1'b0;
            scan_reset_r  <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            sh_r          <= sh_s;
            bits_left_r   <= bits_left_s;
            bytes_rem_r   <= bytes_rem_s;
            vcnt_r        <= vcnt_s;
            crc_r         <= crc_s;
            crc2_r        <= crc2_s;
            verify_mode_r <= verify_mode_s;
            verify_ok_r   <= verify_ok_s;
            crc_out_r     <= crc_out_s;
            byte_ready_r  <= byte_ready_s;
            scan_in_r     <= scan_in_s;
            scan_en_r     <= scan_en_s;
            scan_reset_r  <= scan_reset_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
        end
    end

    // Recirculation must see the tail bit in the same cycle, so VERIFY bypasses the flop.
    assign scan_in    = (state_r == ST_VERIFY) ? scan_out : scan_in_r;
    assign scan_en    = scan_en_r;
    assign scan_reset = scan_reset_r;
    assign byte_ready = byte_ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign verify_ok  = verify_ok_r;
    assign crc_out    = crc_out_r;

endmodule
